// File: rtl/sha_ctrl_fsm_if.sv
// Bundles the command, hash-core and transmitter signals of the SHA controller.
// The controller takes the slave modport; the command/hash/UART side takes master.
interface sha_ctrl_fsm_if #(
    parameter int SEND_W = 256,
    parameter int CNT_W  = 8
);
    logic                  cmd_valid;
    logic [7:0]            Command;
    logic [2*SEND_W-1:0]   chunk;
    logic [SEND_W-1:0]     digest;
    logic                  DigestReady;
    logic                  DigestTransmitted;
    logic                  hash_start;
    logic                  hash_init;
    logic                  transmit_start;
    logic [SEND_W-1:0]     send;
    logic                  busy;
    logic [CNT_W-1:0]      chunk_count;
    logic [2:0]            err_flags;

    modport master (
        output cmd_valid, Command, chunk, digest, DigestReady, DigestTransmitted,
        input  hash_start, hash_init, transmit_start, send, busy, chunk_count, err_flags
    );

    modport slave (
        input  cmd_valid, Command, chunk, digest, DigestReady, DigestTransmitted,
        output hash_start, hash_init, transmit_start, send, busy, chunk_count, err_flags
    );
endinterface

// File: rtl/sha_ctrl_fsm.sv
// Command sequencer between a UART receiver, a SHA hash core and a UART transmitter.
// Define SHA_CTRL_STATUS_EN to enable the 0x06 status-readout command.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for a command strobe; the only state that decodes
// S_HASH_GO   | hash_start pulse; timeout timer loaded
// S_HASH_WAIT | waiting for DigestReady rising edge or timer terminal count
// S_TX_GO     | transmit_start pulse; send already loaded
// S_TX_WAIT   | waiting for DigestTransmitted
module sha_ctrl_fsm #(
    parameter int SEND_W    = 256,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 1024,
    parameter int AUTO_SEND = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    sha_ctrl_fsm_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CMD_CLEAR  = 8'h00;
    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_DIGEST = 8'h02;
    localparam logic [7:0] CMD_HI     = 8'h03;
    localparam logic [7:0] CMD_LO     = 8'h04;
    localparam logic [7:0] CMD_CONT   = 8'h05;
`ifdef SHA_CTRL_STATUS_EN
    localparam logic [7:0] CMD_STATUS = 8'h06;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HASH_GO,
        S_HASH_WAIT,
        S_TX_GO,
        S_TX_WAIT
    } state_t;

    state_t              state_q, state_nxt;
    logic [SEND_W-1:0]   send_q, send_nxt;
    logic                hinit_q, hinit_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [2:0]          err_q, err_nxt;
    logic [TMR_W-1:0]    tmr_q, tmr_nxt;
    logic                dr_q;
    logic                dr_edge;

    // dr_q tracks DigestReady in every state, so a level already high when
    // HASH_WAIT is entered never looks like a fresh edge.
    assign dr_edge = (state_q == S_HASH_WAIT) && bus.DigestReady && !dr_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            send_q  <= '0;
            hinit_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            tmr_q   <= '0;
            dr_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            send_q  <= send_nxt;
            hinit_q <= hinit_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            tmr_q   <= tmr_nxt;
            dr_q    <= bus.DigestReady;
        end
    end

    always_comb begin
        state_nxt = state_q;
        send_nxt  = send_q;
        hinit_nxt = hinit_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        tmr_nxt   = tmr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.Command)
                        CMD_CLEAR: err_nxt = '0;
                        CMD_START: begin
                            hinit_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = S_HASH_GO;
                        end
                        CMD_CONT: begin
                            hinit_nxt = 1'b0;
                            state_nxt = S_HASH_GO;
                        end
                        CMD_DIGEST: begin
                            send_nxt  = bus.digest;
                            state_nxt = S_TX_GO;
                        end
                        CMD_HI: begin
                            send_nxt  = bus.chunk[2*SEND_W-1:SEND_W];
                            state_nxt = S_TX_GO;
                        end
                        CMD_LO: begin
                            send_nxt  = bus.chunk[SEND_W-1:0];
                            state_nxt = S_TX_GO;
                        end
`ifdef SHA_CTRL_STATUS_EN
                        CMD_STATUS: begin
                            send_nxt  = SEND_W'({err_q, cnt_q});
                            state_nxt = S_TX_GO;
                        end
`endif
                        default: err_nxt[0] = 1'b1;
                    endcase
                end
            end
            S_HASH_GO: begin
                tmr_nxt   = TMR_W'(TIMEOUT);
                state_nxt = S_HASH_WAIT;
            end
            S_HASH_WAIT: begin
                if (dr_edge) begin
                    if (cnt_q != '1)
                        cnt_nxt = cnt_q + CNT_W'(1);
                    tmr_nxt = '0;
                    if (AUTO_SEND != 0) begin
                        send_nxt  = bus.digest;
                        state_nxt = S_TX_GO;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (tmr_q <= TMR_W'(1)) begin
                    // Terminal count: this is the last permitted HASH_WAIT cycle.
                    err_nxt[2] = 1'b1;
                    tmr_nxt    = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    tmr_nxt = tmr_q - TMR_W'(1);
                end
            end
            S_TX_GO: state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (bus.DigestTransmitted)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.cmd_valid && (state_q != S_IDLE))
            err_nxt[1] = 1'b1;
    end

    assign bus.hash_start     = (state_q == S_HASH_GO);
    assign bus.hash_init      = hinit_q;
    assign bus.transmit_start = (state_q == S_TX_GO);
    assign bus.send           = send_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.chunk_count    = cnt_q;
    assign bus.err_flags      = err_q;
endmodule

// File: doc/sha_ctrl_fsm.md
SHA_CTRL_FSM -- requirements
Module: sha_ctrl_fsm

Interface
REQ-001 SHALL have parameter SEND_W, default 256: digest width and UART send width; chunk width is 2*SEND_W.
REQ-002 SHALL have parameter CNT_W, default 8: width of the message chunk counter.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum HASH_WAIT cycles before abort.
REQ-004 SHALL have parameter AUTO_SEND, default 1: 1 = transmit the digest automatically after each hash.
REQ-005 SHALL have port Clk  in  1  clock; one clock domain, all logic on the rising edge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  in  1  one-cycle strobe qualifying Command.
REQ-008 SHALL have port Command  in  8  command byte from the UART receiver.
REQ-009 SHALL have port chunk  in  2*SEND_W  current received chunk.
REQ-010 SHALL have port digest  in  SEND_W  hash core result.
REQ-011 SHALL have port DigestReady  in  1  hash core done level.
REQ-012 SHALL have port DigestTransmitted  in  1  transmitter done pulse.
REQ-013 SHALL have port hash_start  out  1  one-cycle hash core start pulse.
REQ-014 SHALL have port hash_init  out  1  valid with hash_start; 1 = load initial H values, 0 = chain from previous digest.
REQ-015 SHALL have port transmit_start  out  1  one-cycle transmitter start pulse.
REQ-016 SHALL have port send  out  SEND_W  transmit buffer, stable from transmit_start until DigestTransmitted.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port chunk_count  out  CNT_W  chunks hashed in the current message.
REQ-019 SHALL have port err_flags  out  3  sticky flags: [0] unknown command, [1] command while busy, [2] hash timeout.

Function
REQ-020 SHALL implement states IDLE, HASH_GO, HASH_WAIT, TX_GO, TX_WAIT.
REQ-021 SHALL sample Command only when cmd_valid=1; Command is ignored otherwise.
REQ-022 SHALL, in IDLE on 0x01, enter HASH_GO with hash_init=1 and clear chunk_count to 0.
REQ-023 SHALL, in IDLE on 0x05, enter HASH_GO with hash_init=0 (continuation chunk).
REQ-024 SHALL pulse hash_start for exactly one cycle in HASH_GO, then enter HASH_WAIT.
REQ-025 SHALL detect the DigestReady rising edge (registered previous value) in HASH_WAIT; on that edge it SHALL increment chunk_count, saturating at all-ones.
REQ-026 SHALL, after that DigestReady edge, load send<=digest and enter TX_GO when AUTO_SEND=1; otherwise it SHALL return to IDLE.
REQ-027 SHALL, in IDLE, load send and enter TX_GO on: 0x02 -> digest; 0x03 -> chunk[2*SEND_W-1:SEND_W]; 0x04 -> chunk[SEND_W-1:0].
REQ-028 SHALL pulse transmit_start for exactly one cycle in TX_GO, then enter TX_WAIT.
REQ-029 SHALL return from TX_WAIT to IDLE on DigestTransmitted.
REQ-030 SHALL, on 0x00 in IDLE, clear err_flags and stay in IDLE.
REQ-031 SHALL, on any other byte in IDLE, set err_flags[0] and stay in IDLE.
REQ-032 SHALL drop any cmd_valid received outside IDLE and set err_flags[1], with no state change.
REQ-033 SHALL count cycles in HASH_WAIT; on reaching TIMEOUT without a DigestReady edge it SHALL set err_flags[2] and return to IDLE with chunk_count unchanged.
REQ-034 SHALL ignore DigestReady outside HASH_WAIT; a DigestReady already high on entry to HASH_WAIT SHALL NOT count as an edge.
REQ-035 SHALL give a command latency of exactly one cycle: cmd_valid in cycle N produces hash_start or transmit_start in cycle N+1.

Reset
REQ-036 SHALL, on Reset=1 at a clock edge, force state=IDLE, hash_start=0, hash_init=0, transmit_start=0, send=0, chunk_count=0, err_flags=0, timeout counter=0 and the registered DigestReady=0.
REQ-037 SHALL, when reset is asserted mid-hash or mid-transmit, abandon the operation and emit no further start pulses.

Configuration
REQ-038 SHALL, with SHA_CTRL_STATUS_EN defined, decode 0x06 in IDLE: send<={zeros, err_flags, chunk_count} (LSB-aligned, zero-extended), then enter TX_GO.
REQ-039 SHALL, without SHA_CTRL_STATUS_EN defined, treat 0x06 as an unknown command (set err_flags[0]).

Verification
REQ-040 SHALL cover: 0x01, DigestReady rises 40 cycles later, AUTO_SEND=1 -> one hash_start with hash_init=1; send=digest; one transmit_start; chunk_count=1.
REQ-041 SHALL cover: 0x01, then 0x05, 0x05 (each run to completion) -> hash_init sequence 1,0,0; chunk_count=3.
REQ-042 SHALL cover: 0x03 with chunk upper half=256'hA5..A5 -> send=256'hA5..A5 one cycle after cmd_valid; busy stays high until DigestTransmitted.
REQ-043 SHALL cover: 0x02 issued during HASH_WAIT -> command dropped; err_flags=3'b010; then 0x00 -> err_flags=0.
REQ-044 SHALL cover: TIMEOUT=100 with DigestReady held low -> err_flags[2]=1 after exactly 100 HASH_WAIT cycles; back in IDLE; no transmit_start.
REQ-045 SHALL cover: 0x06 with err_flags=3'b001 and chunk_count=5 -> send=0x105 if SHA_CTRL_STATUS_EN is defined; otherwise no transmit and err_flags[0]=1.
